// File: rtl/ov7670_capture.sv
// ov7670_capture: brings a raw OV7670 DVP bus (pclk/href/vsync/data) into the
// system clock domain and writes RGB565 pixels into a linear frame buffer.
// Optional build macro CAPTURE_DECIMATE_EN keeps only even columns of even
// lines; without it every pixel of the frame is written.
module ov7670_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [7:0]        cam_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [9:0]        line_count
);

  // Addresses stop advancing here; anything beyond is dropped, never wrapped.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(H_PIXELS * V_LINES);

`ifdef CAPTURE_DECIMATE_EN
  // A clean decimated frame keeps one pixel out of every 2x2 block.
  localparam logic [ADDR_W-1:0] FRAME_WRITES = ADDR_W'((H_PIXELS / 2) * (V_LINES / 2));
`else
  localparam logic [ADDR_W-1:0] FRAME_WRITES = ADDR_LIMIT;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    SYNC    = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  // Camera control bits are packed as {vsync, href, pclk}.
  logic [2:0]        camS1_q;
  logic [2:0]        camS2_q;
  logic [2:0]        camS3_q;
  logic [7:0]        dS1_q;
  logic [7:0]        dS2_q;
  logic [7:0]        dS3_q;

  logic              pclkRise_q;
  logic              hrefFall_q;
  logic              vsRise_q;
  logic              vsFall_q;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [ADDR_W-1:0] wrAddr_d;
  logic [15:0]       wrData_q;
  logic [15:0]       wrData_d;
  logic              wrEn_q;
  logic              wrEn_d;
  logic              frameDone_q;
  logic              frameDone_d;
  logic              frameErr_q;
  logic              frameErr_d;
  logic [9:0]        lineCount_q;
  logic [9:0]        lineCount_d;
  logic              phase_q;
  logic              phase_d;
  logic [7:0]        hiByte_q;
  logic [7:0]        hiByte_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              keepPixel;
`ifdef CAPTURE_DECIMATE_EN
  logic              colOdd_q;
  logic              colOdd_d;
`endif

  // Two-flop synchronizers, a third aligned stage, and registered edge pulses.
  // The third stage doubles as the "previous" value for edge detection and as
  // the href/data snapshot that lines up with the registered pclk rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      camS1_q    <= '0;
      camS2_q    <= '0;
      camS3_q    <= '0;
      dS1_q      <= '0;
      dS2_q      <= '0;
      dS3_q      <= '0;
      pclkRise_q <= 1'b0;
      hrefFall_q <= 1'b0;
      vsRise_q   <= 1'b0;
      vsFall_q   <= 1'b0;
    end else begin
      camS1_q    <= {cam_vsync, cam_href, cam_pclk};
      camS2_q    <= camS1_q;
      camS3_q    <= camS2_q;
      dS1_q      <= cam_d;
      dS2_q      <= dS1_q;
      dS3_q      <= dS2_q;
      pclkRise_q <= camS2_q[0] & ~camS3_q[0];
      hrefFall_q <= ~camS2_q[1] & camS3_q[1];
      vsRise_q   <= camS2_q[2] & ~camS3_q[2];
      vsFall_q   <= ~camS2_q[2] & camS3_q[2];
    end
  end

  // Next-state logic: frame sequencing, byte pairing, line and frame accounting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    wrEn_d      = 1'b0;
    frameDone_d = 1'b0;
    frameErr_d  = 1'b0;
    lineCount_d = lineCount_q;
    phase_d     = phase_q;
    hiByte_d    = hiByte_q;
    overflow_d  = overflow_q;
    keepPixel   = 1'b1;
`ifdef CAPTURE_DECIMATE_EN
    colOdd_d    = colOdd_q;
    keepPixel   = ~colOdd_q & ~lineCount_q[0];
`endif

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_VS;
        end
      end

      WAIT_VS: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vsRise_q) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vsFall_q) begin
          state_d     = ACTIVE;
          addr_d      = '0;
          lineCount_d = '0;
          phase_d     = 1'b0;
          overflow_d  = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
          colOdd_d    = 1'b0;
`endif
        end
      end

      ACTIVE: begin
        // Byte capture: first byte of a pixel is the high half.
        if (pclkRise_q && camS3_q[1]) begin
          if (!phase_q) begin
            hiByte_d = dS3_q;
            phase_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
            colOdd_d = ~colOdd_q;
`endif
            if (keepPixel) begin
              if (addr_q == ADDR_LIMIT) begin
                overflow_d = 1'b1;
              end else begin
                wrEn_d   = 1'b1;
                wrAddr_d = addr_q;
                wrData_d = {hiByte_q, dS3_q};
                addr_d   = addr_q + ADDR_W'(1);
              end
            end
          end
        end

        // Line end is folded in before the frame-end decision below, so a
        // dangling byte on the last line still marks the frame as bad.
        if (hrefFall_q) begin
          if (phase_d) begin
            overflow_d = 1'b1;
          end
          phase_d = 1'b0;
          if (lineCount_q != 10'h3FF) begin
            lineCount_d = lineCount_q + 10'd1;
          end
`ifdef CAPTURE_DECIMATE_EN
          colOdd_d = 1'b0;
`endif
        end

        // The write count equals the address, since it never wraps.
        if (vsRise_q) begin
          if ((addr_d == FRAME_WRITES) && !overflow_d) begin
            frameDone_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
          state_d = enable ? SYNC : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      wrEn_q      <= 1'b0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
      lineCount_q <= '0;
      phase_q     <= 1'b0;
      hiByte_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      wrEn_q      <= wrEn_d;
      frameDone_q <= frameDone_d;
      frameErr_q  <= frameErr_d;
      lineCount_q <= lineCount_d;
      phase_q     <= phase_d;
      hiByte_q    <= hiByte_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef CAPTURE_DECIMATE_EN
  // Column parity tracker used to keep only even columns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      colOdd_q <= 1'b0;
    end else begin
      colOdd_q <= colOdd_d;
    end
  end
`endif

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign frame_done = frameDone_q;
  assign frame_err  = frameErr_q;
  assign line_count = lineCount_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: drives directed camera frames at pclk = clk/4 and checks
// writes and end-of-frame pulses through a scoreboard and a separate monitor.
module tb_ov7670_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 19;
`ifdef CAPTURE_DECIMATE_EN
  localparam bit DECIMATE   = 1'b1;
  localparam int EXP_WRITES = (H / 2) * (V / 2);
`else
  localparam bit DECIMATE   = 1'b0;
  localparam int EXP_WRITES = H * V;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          cam_pclk  = 1'b0;
  logic          cam_href  = 1'b0;
  logic          cam_vsync = 1'b0;
  logic [7:0]    cam_d     = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          frame_err;
  logic [9:0]    line_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } wr_t;

  wr_t  wrQ[$];
  int   evQ[$];
  wr_t  monE;
  int   monEv;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  int         mState = 0;
  int         mAddr  = 0;
  int         mLine  = 0;
  int         mCol   = 0;
  bit         mOvf   = 1'b0;
  logic [7:0] bNext  = 8'h12;

  ov7670_capture #(
    .H_PIXELS(H),
    .V_LINES (V),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cam_pclk  (cam_pclk),
    .cam_href  (cam_href),
    .cam_vsync (cam_vsync),
    .cam_d     (cam_d),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .line_count(line_count)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Cycle counter used to verify write latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or frame pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en === 1'b1) begin
        if (wrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: actual addr=0x%0h data=0x%0h required no write", wr_addr, wr_data);
        end else begin
          monE = wrQ.pop_front();
          checkOutput("wr_addr", 32'(wr_addr), 32'(monE.addr));
          checkOutput("wr_data", 32'(wr_data), 32'(monE.data));
          checkOutput("wr_latency_cycle", cyc, monE.cyc);
        end
      end
      if ((frame_done === 1'b1) || (frame_err === 1'b1)) begin
        if ((frame_done === 1'b1) && (frame_err === 1'b1)) begin
          checks++;
          errors++;
          $display("[TB] FAIL frame_pulse_both: actual done=1 err=1 required exactly one");
        end else if (evQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame_pulse: actual done=%0b err=%0b required none", frame_done, frame_err);
        end else begin
          monEv = evQ.pop_front();
          checkOutput("frame_event_is_err", 32'(frame_err), 32'(monEv));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera byte: data set with pclk low, then pclk high for two clocks.
  task automatic camByte(input logic [7:0] b, output int riseCyc);
    cam_pclk = 1'b0;
    cam_d    = b;
    tick(2);
    cam_pclk = 1'b1;
    riseCyc  = cyc;
    tick(2);
  endtask

  task automatic modelPixel(input logic [7:0] hi, input logic [7:0] lo, input int riseCyc);
    bit  keep;
    wr_t e;
    if (mState == 3) begin
      keep = !DECIMATE || (((mCol % 2) == 0) && ((mLine % 2) == 0));
      if (keep) begin
        if (mAddr >= H * V) begin
          mOvf = 1'b1;
        end else begin
          e.addr = AW'(mAddr);
          e.data = {hi, lo};
          e.cyc  = riseCyc + 4;
          wrQ.push_back(e);
          mAddr++;
        end
      end
      mCol++;
    end
  endtask

  task automatic lineBytes(input int nBytes, input int dropEnAt);
    logic [7:0] hi;
    int         rc;
    hi       = 8'h00;
    cam_href = 1'b1;
    for (int k = 0; k < nBytes; k++) begin
      if (k == dropEnAt) enable = 1'b0;
      camByte(bNext, rc);
      if ((k % 2) == 0) hi = bNext;
      else modelPixel(hi, bNext, rc);
      bNext = bNext + 8'h22;
    end
  endtask

  // Line end, followed by a couple of pclk pulses with href low.
  task automatic lineEnd(input int nBytes);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    if (mState == 3) begin
      if ((nBytes % 2) != 0) mOvf = 1'b1;
      mLine++;
      mCol = 0;
    end
    tick(4);
    repeat (2) begin
      cam_pclk = 1'b1;
      tick(2);
      cam_pclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic vsRiseT();
    cam_vsync = 1'b1;
    if (mState == 1) begin
      mState = 2;
    end else if (mState == 3) begin
      evQ.push_back(((mAddr == EXP_WRITES) && !mOvf) ? 0 : 1);
      mState = enable ? 2 : 0;
    end
    tick(8);
  endtask

  task automatic vsFallT();
    cam_vsync = 1'b0;
    if (mState == 2) begin
      mState = 3;
      mAddr  = 0;
      mLine  = 0;
      mCol   = 0;
      mOvf   = 1'b0;
    end
    tick(8);
  endtask

  task automatic applyStimulus(input int bytes0, input int bytes1, input int dropEnAt);
    vsFallT();
    bNext = 8'h12;
    lineBytes(bytes0, dropEnAt);
    lineEnd(bytes0);
    lineBytes(bytes1, -1);
    lineEnd(bytes1);
    vsRiseT();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    checkOutput({tag, "_line_count"}, 32'(line_count), 32'd0);
  endtask

  // Directed sequence of frames.
  initial begin
    rst_n = 1'b0;
    tick(3);
    checkResetOutputs("reset");
    rst_n  = 1'b1;
    enable = 1'b1;
    mState = 1;
    tick(2);
    vsRiseT();

    // Good frame: 2 lines of 4 pixels.
    applyStimulus(2 * H * 2 / 2, 2 * H, -1);
    checkOutput("line_count_good", 32'(line_count), 32'd2);

    // Second line one byte short: dangling byte dropped, frame error.
    applyStimulus(2 * H, 2 * H - 1, -1);
    checkOutput("line_count_dangling", 32'(line_count), 32'd2);

    // Ten pixels per line: writes stop at the limit, frame error.
    applyStimulus(20, 20, -1);
    checkOutput("line_count_overflow", 32'(line_count), 32'd2);

    // Reset after three pixels of line 0: no end pulse, restart on full vsync.
    vsFallT();
    bNext = 8'h12;
    lineBytes(6, -1);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    checkResetOutputs("midframe_reset");
    rst_n  = 1'b1;
    mState = 1;
    lineEnd(6);
    lineBytes(2 * H, -1);
    lineEnd(2 * H);
    vsRiseT();
    applyStimulus(2 * H, 2 * H, -1);

    // Enable dropped during line 0: frame completes, then nothing more.
    applyStimulus(2 * H, 2 * H, 2);
    applyStimulus(2 * H, 2 * H, -1);

    tick(10);
    checkOutput("pending_writes", 32'(wrQ.size()), 32'd0);
    checkOutput("pending_frame_events", 32'(evQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
